// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants and helpers for the multiport register file
// Optional feature macro: RF_BYPASS_EN (write-through forwarding in rf_multiport)
package rf_pkg;

  // Architectural register that is hardwired to zero.
  localparam int ZERO_REG = 0;

  // Default geometry of the core's register file.
  localparam int RF_DATA_W_DEF = 32;
  localparam int RF_NREGS_DEF  = 32;
  localparam int RF_NRD_DEF    = 2;
  localparam int RF_NWR_DEF    = 2;

  // Register-specifier field positions in a 32-bit instruction word,
  // shared with the decode and hazard units.
  localparam int FLD_RD_LSB  = 7;
  localparam int FLD_RS1_LSB = 15;
  localparam int FLD_RS2_LSB = 20;
  localparam int FLD_REG_W   = 5;

  // Index width for a register count; $clog2 wrapper kept in one place.
  function automatic int rf_idx_w(input int nregs);
    return $clog2(nregs);
  endfunction

endpackage

// File: rtl/rf_pending_table.sv
// rtl/rf_pending_table.sv - per-register pending scoreboard with set-over-clear priority
module rf_pending_table
  import rf_pkg::*;
#(
  parameter int NREGS = RF_NREGS_DEF,
  parameter int NRD   = RF_NRD_DEF,
  parameter int NWR   = RF_NWR_DEF,
  parameter int IDX_W = rf_idx_w(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*IDX_W-1:0] wr_idx,
  input  logic                 iss_en,
  input  logic [IDX_W-1:0]     iss_idx,
  input  logic [NRD*IDX_W-1:0] rd_idx,
  output logic [NRD-1:0]       rd_pending,
  output logic                 any_pending
);

  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_nxt;

  // Writebacks clear first, then an issue sets, so a same-cycle newer producer wins; x0 never pends.
  always_comb begin
    pending_nxt = pending;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p] && (wr_idx[p*IDX_W +: IDX_W] != IDX_W'(ZERO_REG))) begin
        pending_nxt[wr_idx[p*IDX_W +: IDX_W]] = 1'b0;
      end
    end
    if (iss_en && (iss_idx != IDX_W'(ZERO_REG))) begin
      pending_nxt[iss_idx] = 1'b1;
    end
    pending_nxt[ZERO_REG] = 1'b0;
  end

  // Scoreboard register; reset drops every outstanding producer.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  // Per-read-port lookup and drain indication from the registered vector.
  always_comb begin
    rd_pending = '0;
    for (int r = 0; r < NRD; r++) begin
      rd_pending[r] = pending[rd_idx[r*IDX_W +: IDX_W]];
    end
    any_pending = |pending;
  end

endmodule

// File: rtl/rf_multiport.sv
// rtl/rf_multiport.sv - NRD-read / NWR-write register file with pending scoreboard
// Optional feature macro: RF_BYPASS_EN (same-cycle write-to-read forwarding)
module rf_multiport
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W_DEF,
  parameter int NREGS  = RF_NREGS_DEF,
  parameter int NRD    = RF_NRD_DEF,
  parameter int NWR    = RF_NWR_DEF,
  parameter int IDX_W  = rf_idx_w(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*IDX_W-1:0]  wr_idx,
  input  logic [NWR*DATA_W-1:0] wr_data,
  input  logic [NRD*IDX_W-1:0]  rd_idx,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_pending,
  input  logic                  iss_en,
  input  logic [IDX_W-1:0]      iss_idx,
  output logic                  any_pending
);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NRD-1:0]    tbl_pending;

  rf_pending_table #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR),
    .IDX_W (IDX_W)
  ) u_pending (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .iss_en      (iss_en),
    .iss_idx     (iss_idx),
    .rd_idx      (rd_idx),
    .rd_pending  (tbl_pending),
    .any_pending (any_pending)
  );

  // Data array; ports are visited in ascending order so the highest enabled port wins a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] && (wr_idx[p*IDX_W +: IDX_W] != IDX_W'(ZERO_REG))) begin
          regs[wr_idx[p*IDX_W +: IDX_W]] <= wr_data[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Read ports: array contents, optionally overridden by a same-cycle writeback to the same index.
  always_comb begin
    rd_data    = '0;
    rd_pending = '0;
    for (int r = 0; r < NRD; r++) begin
      rd_data[r*DATA_W +: DATA_W] = regs[rd_idx[r*IDX_W +: IDX_W]];
      rd_pending[r]               = tbl_pending[r];
`ifdef RF_BYPASS_EN
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] && (rd_idx[r*IDX_W +: IDX_W] != IDX_W'(ZERO_REG)) &&
            (wr_idx[p*IDX_W +: IDX_W] == rd_idx[r*IDX_W +: IDX_W])) begin
          rd_data[r*DATA_W +: DATA_W] = wr_data[p*DATA_W +: DATA_W];
          if (!(iss_en && (iss_idx == rd_idx[r*IDX_W +: IDX_W]))) begin
            rd_pending[r] = 1'b0;
          end
        end
      end
`endif
    end
  end

endmodule
